dft_sequencer: RTL and testbench

DFT_SEQUENCER -- requirements
Module: dft_sequencer

---
 rtl/fft_pkg.sv | 16 +
 rtl/dft_sequencer_idx_counter.sv | 38 +++
 rtl/dft_sequencer.sv | 161 ++++++++++++++++
 tb/tb_dft_sequencer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types and constants for the DFT sequencer slice.
// Holds the sequencer state encoding and the default index width.
package fft_pkg;

  localparam int AW = 12;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    FILL = 3'd2,
    ACC  = 3'd3,
    WB   = 3'd4,
    DONE = 3'd5
  } state_t;

endpackage

// File: rtl/dft_sequencer_idx_counter.sv
// Wrapping index counter used for the sample (n) and bin (k) indices.
// wrap flags that the count sits at max, so the next enabled step returns to zero.
module idx_counter #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ce,
  input  logic         clear,
  input  logic [W-1:0] max,
  output logic [W-1:0] count,
  output logic         wrap
);

  logic [W-1:0] count_r;

  assign count = count_r;
  // wrap is a pure decode of the count so the parent FSM can use it without a loop through ce
  assign wrap  = (count_r == max);

  // counter register: clear has priority over the enabled step
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= {W{1'b0}};
    end else if (clear) begin
      count_r <= {W{1'b0}};
    end else if (ce) begin
      if (count_r == max) begin
        count_r <= {W{1'b0}};
      end else begin
        count_r <= count_r + {{(W-1){1'b0}}, 1'b1};
      end
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/dft_sequencer.sv
// Control sequencer for a direct O(N^2) DFT: loads samples into a cache, then
// accumulates N products per bin and writes each bin back.
module dft_sequencer #(
  parameter int AW = fft_pkg::AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [AW-1:0] samp_number,
  input  logic          data_loaded,
  output logic          busy,
  output logic          ram_mode,
  output logic          cache_we,
  output logic [AW-1:0] n_index,
  output logic [AW-1:0] k_index,
  output logic          acc_ce,
  output logic          acc_clr,
  output logic          wb_we,
  output logic          calc_end,
  output logic          err
);

  import fft_pkg::*;

  state_t        state_r;
  state_t        state_s;
  logic [AW-1:0] n_len_r;
  logic [AW-1:0] n_max_s;
  logic          err_r;
  logic          accept_s;
  logic          reject_s;
  logic          n_ce_s;
  logic          k_ce_s;
  logic          n_clear_s;
  logic          k_clear_s;
  logic          n_wrap_s;
  logic          k_wrap_s;

  assign accept_s  = (state_r == IDLE) && start && (samp_number >= AW'(2));
  assign reject_s  = (state_r == IDLE) && start && (samp_number <  AW'(2));
  assign n_max_s   = n_len_r - AW'(1);
  assign n_clear_s = accept_s;
  assign k_clear_s = accept_s || (state_r == DONE);
  assign busy      = (state_r != IDLE);
  assign err       = err_r;

  idx_counter #(.W(AW)) u_n_cnt (
    .clk   (clk),
    .rst   (rst),
    .ce    (n_ce_s),
    .clear (n_clear_s),
    .max   (n_max_s),
    .count (n_index),
    .wrap  (n_wrap_s)
  );

  idx_counter #(.W(AW)) u_k_cnt (
    .clk   (clk),
    .rst   (rst),
    .ce    (k_ce_s),
    .clear (k_clear_s),
    .max   (n_max_s),
    .count (k_index),
    .wrap  (k_wrap_s)
  );

  // state, latched length and the registered reject pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      n_len_r <= {AW{1'b0}};
      err_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      err_r   <= reject_s;
      if (accept_s) begin
        n_len_r <= samp_number;
      end else begin
        n_len_r <= n_len_r;
      end
    end
  end

  // next-state and strobe decode; abort overrides every busy state
  always_comb begin
    state_s  = state_r;
    ram_mode = 1'b1;
    cache_we = 1'b0;
    acc_ce   = 1'b0;
    acc_clr  = 1'b0;
    wb_we    = 1'b0;
    calc_end = 1'b0;
    n_ce_s   = 1'b0;
    k_ce_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = LOAD;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: begin
        if (data_loaded) begin
          state_s = FILL;
        end else begin
          state_s = LOAD;
        end
      end
      FILL: begin
        cache_we = 1'b1;
        n_ce_s   = 1'b1;
        if (n_wrap_s) begin
          state_s = ACC;
        end else begin
          state_s = FILL;
        end
      end
      ACC: begin
        ram_mode = 1'b0;
        acc_ce   = 1'b1;
        n_ce_s   = 1'b1;
        if (n_wrap_s) begin
          state_s = WB;
        end else begin
          state_s = ACC;
        end
      end
      WB: begin
        ram_mode = 1'b0;
        wb_we    = 1'b1;
        acc_clr  = 1'b1;
        k_ce_s   = 1'b1;
        if (k_wrap_s) begin
          state_s = DONE;
        end else begin
          state_s = ACC;
        end
      end
      DONE: begin
        calc_end = 1'b1;
        state_s  = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    if (abort && (state_r != IDLE)) begin
      state_s  = IDLE;
      acc_clr  = 1'b1;
      wb_we    = 1'b0;
      calc_end = 1'b0;
      n_ce_s   = 1'b0;
      k_ce_s   = 1'b0;
    end else begin
      state_s  = state_s;
    end
  end

endmodule

// File: tb/tb_dft_sequencer.sv
// Scoreboard bench for dft_sequencer: stimulus queues expected strobe events,
// a negedge monitor turns observed strobes into events and compares them.
module tb_dft_sequencer;

  localparam int AW = 12;
  localparam int K_FILL = 1;
  localparam int K_WB   = 2;
  localparam int K_DONE = 3;
  localparam int K_ERR  = 4;
  localparam int K_ABC  = 5;

  typedef struct {
    int kind;
    int idx;
    int cnt;
    int flag;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] samp_number = '0;
  logic          data_loaded = 1'b0;
  logic          busy, ram_mode, cache_we, acc_ce, acc_clr, wb_we, calc_end, err;
  logic [AW-1:0] n_index, k_index;

  ev_t exp_q[$];
  int  total = 0;
  int  bad = 0;
  int  cyc = 0;
  int  fill_start = 0;
  int  acc_cnt = 0;

  dft_sequencer #(.AW(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .samp_number (samp_number),
    .data_loaded (data_loaded),
    .busy        (busy),
    .ram_mode    (ram_mode),
    .cache_we    (cache_we),
    .n_index     (n_index),
    .k_index     (k_index),
    .acc_ce      (acc_ce),
    .acc_clr     (acc_clr),
    .wb_we       (wb_we),
    .calc_end    (calc_end),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic push(input int kind, input int idx, input int cnt, input int flag);
    ev_t e;
    e.kind = kind; e.idx = idx; e.cnt = cnt; e.flag = flag;
    exp_q.push_back(e);
  endtask

  task automatic push_run(input int n);
    for (int i = 0; i < n; i++) push(K_FILL, i, 0, 1);
    for (int k = 0; k < n; k++) push(K_WB, k, n, 1);
    push(K_DONE, 0, n + n * (n + 1), 1);
  endtask

  task automatic got_ev(input ev_t g);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL ev_unexpected got kind=%0d idx=%0d cnt=%0d flag=%0d want none",
               g.kind, g.idx, g.cnt, g.flag);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != g.kind || e.idx != g.idx || e.cnt != g.cnt || e.flag != g.flag) begin
        bad++;
        $display("FAIL ev_compare got kind=%0d idx=%0d cnt=%0d flag=%0d want kind=%0d idx=%0d cnt=%0d flag=%0d",
                 g.kind, g.idx, g.cnt, g.flag, e.kind, e.idx, e.cnt, e.flag);
      end
    end
  endtask

  // monitor: one event per observed strobe, sampled on the falling edge
  initial begin
    ev_t g;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        acc_cnt = 0;
      end else begin
        if (cache_we) begin
          if (n_index == 0) fill_start = cyc;
          g.kind = K_FILL; g.idx = int'(n_index); g.cnt = 0; g.flag = int'(ram_mode);
          got_ev(g);
        end
        if (acc_ce) begin
          chk("acc_ram_mode", int'(ram_mode), 0);
          chk("acc_n_index", int'(n_index), acc_cnt);
          acc_cnt++;
        end
        if (wb_we) begin
          g.kind = K_WB; g.idx = int'(k_index); g.cnt = acc_cnt; g.flag = int'(acc_clr);
          got_ev(g);
          acc_cnt = 0;
        end
        if (acc_clr && !wb_we) begin
          g.kind = K_ABC; g.idx = 0; g.cnt = 0; g.flag = int'(calc_end);
          got_ev(g);
          acc_cnt = 0;
        end
        if (calc_end) begin
          g.kind = K_DONE; g.idx = 0; g.cnt = cyc - fill_start; g.flag = int'(busy);
          got_ev(g);
        end
        if (err) begin
          g.kind = K_ERR; g.idx = 0; g.cnt = 0; g.flag = int'(busy);
          got_ev(g);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int i;
    i = 0;
    while (busy && i < budget) begin
      tick();
      i++;
    end
    chk(name, int'(busy), 0);
  endtask

  task automatic issue(input int n);
    samp_number = AW'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int i;
    // reset state
    tick(); tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_ram_mode", int'(ram_mode), 1);
    chk("rst_strobes", int'({cache_we, acc_ce, acc_clr, wb_we, calc_end, err}), 0);
    chk("rst_n_index", int'(n_index), 0);
    chk("rst_k_index", int'(k_index), 0);
    rst = 1'b0;
    tick();

    // N=4, data_loaded rises three cycles after start
    push_run(4);
    issue(4);
    chk("n4_busy", int'(busy), 1);
    tick(); tick(); tick();
    data_loaded = 1'b1;
    wait_idle(100, "n4_timeout");
    data_loaded = 1'b0;
    tick();

    // too-short lengths are rejected
    push(K_ERR, 0, 0, 0);
    issue(1);
    tick();
    chk("n1_busy", int'(busy), 0);
    push(K_ERR, 0, 0, 0);
    issue(0);
    tick(); tick();
    chk("n0_busy", int'(busy), 0);

    // abort during ACC at k=2, n=1
    data_loaded = 1'b1;
    for (int j = 0; j < 4; j++) push(K_FILL, j, 0, 1);
    push(K_WB, 0, 4, 1);
    push(K_WB, 1, 4, 1);
    push(K_ABC, 0, 0, 0);
    issue(4);
    i = 0;
    while (!(acc_ce && k_index == AW'(2) && n_index == AW'(1)) && i < 60) begin
      tick();
      i++;
    end
    chk("abort_sync", int'(acc_ce && k_index == AW'(2) && n_index == AW'(1)), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_clr_off", int'(acc_clr), 0);
    for (int j = 0; j < 10; j++) tick();
    chk("abort_q_empty", exp_q.size(), 0);

    // N=8 with a repeated start in FILL and samp_number changed to 16
    push_run(8);
    issue(8);
    samp_number = AW'(16);
    i = 0;
    while (!cache_we && i < 20) begin
      tick();
      i++;
    end
    chk("n8_fill_seen", int'(cache_we), 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle(300, "n8_timeout");
    tick();

    // asynchronous reset in the middle of a writeback
    for (int j = 0; j < 4; j++) push(K_FILL, j, 0, 1);
    issue(4);
    i = 0;
    while (!wb_we && i < 60) begin
      tick();
      i++;
    end
    chk("rst_wb_seen", int'(wb_we), 1);
    rst = 1'b1;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_strobes", int'({cache_we, acc_ce, acc_clr, wb_we, calc_end}), 0);
    chk("arst_ram_mode", int'(ram_mode), 1);
    chk("arst_k_index", int'(k_index), 0);
    tick();
    rst = 1'b0;
    tick();

    // N=2 with simultaneous abort in IDLE: start wins
    push_run(2);
    samp_number = AW'(2);
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("n2_busy", int'(busy), 1);
    wait_idle(50, "n2_timeout");
    tick(); tick();
    chk("final_q_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
